// File: rtl/core_pkg.sv
// Shared ISA constants, opcode/ALU enums and decode helper for the 8-bit Harvard core.
package core_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned PC_W      = 9;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned REG_N     = 4;
  localparam int unsigned REG_SEL_W = 2;

  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_LSB = 10;
  localparam int unsigned RS_LSB = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_ADDI = 4'h9,
    OP_CMP  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_IN   = 4'hE,
    OP_OUT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  // Map an instruction opcode onto the ALU operation it needs (ADD for non-ALU opcodes).
  function automatic alu_op_e alu_op_of(input opcode_e op);
    case (op)
      OP_SUB, OP_CMP: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_XOR:         return ALU_XOR;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational 8-bit ALU: result plus zero and carry/borrow flags.
module core_alu
  import core_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      ALU_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/core.sv
// Single-cycle 8-bit Harvard CPU top: pc, register file, flags, decode and memory/IO ports.
// Optional IN/OUT opcodes are enabled by defining CORE_IO_EN.
module core
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [DATA_W-1:0]  mem_load,
  input  logic [DATA_W-1:0]  io_input,
  output logic [PC_W-1:0]    instruction_addr,
  output logic               mem_en_load,
  output logic               mem_en_store,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_store,
  output logic [DATA_W-1:0]  io_output
);

  opcode_e              op;
  logic [REG_SEL_W-1:0] rd;
  logic [REG_SEL_W-1:0] rs;
  logic [DATA_W-1:0]    imm8;
  logic [ADDR_W-1:0]    a10;
  logic [PC_W-1:0]      a9;

  assign op   = opcode_e'(instruction[OP_LSB +: OP_W]);
  assign rd   = instruction[RD_LSB +: REG_SEL_W];
  assign rs   = instruction[RS_LSB +: REG_SEL_W];
  assign imm8 = instruction[DATA_W-1:0];
  assign a10  = instruction[ADDR_W-1:0];
  assign a9   = instruction[PC_W-1:0];

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] regs [REG_N];
  logic              flag_z;
  logic              flag_c;

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_z;
  logic              alu_c;

  assign rd_val = regs[rd];
  assign rs_val = regs[rs];
  assign alu_b  = (op == OP_ADDI) ? imm8 : rs_val;

  core_alu u_alu (
    .a      (rd_val),
    .b      (alu_b),
    .op     (alu_op_of(op)),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic              flag_we;
  logic              io_we;
  logic [PC_W-1:0]   pc_next;

  // Decode: register write-back, flag update, next pc and output-port strobe.
  always_comb begin
    reg_we    = 1'b0;
    reg_wdata = '0;
    flag_we   = 1'b0;
    io_we     = 1'b0;
    pc_next   = pc + PC_W'(1);
    case (op)
      OP_LDI: begin
        reg_we    = 1'b1;
        reg_wdata = imm8;
      end
      OP_LD: begin
        reg_we    = 1'b1;
        reg_wdata = mem_load;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
        reg_we    = 1'b1;
        reg_wdata = alu_result;
        flag_we   = 1'b1;
      end
      OP_CMP: flag_we = 1'b1;
      OP_JMP: pc_next = a9;
      OP_JZ:  if (flag_z) pc_next = a9;
      OP_JC:  if (flag_c) pc_next = a9;
`ifdef CORE_IO_EN
      OP_IN: begin
        reg_we    = 1'b1;
        reg_wdata = io_input;
      end
      OP_OUT: io_we = 1'b1;
`endif
      default: ;
    endcase
  end

  // Memory strobes are combinational and held quiet during reset.
  always_comb begin
    mem_en_load  = !rst && (op == OP_LD);
    mem_en_store = !rst && (op == OP_ST);
    mem_addr     = (mem_en_load || mem_en_store) ? a10 : '0;
    mem_store    = mem_en_store ? rd_val : '0;
  end

  assign instruction_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (reg_we) regs[rd] <= reg_wdata;
      if (flag_we) begin
        flag_z <= alu_z;
        flag_c <= alu_c;
      end
    end
  end

`ifdef CORE_IO_EN
  logic [DATA_W-1:0] io_q;

  always_ff @(posedge clk) begin
    if (rst)        io_q <= '0;
    else if (io_we) io_q <= rd_val;
  end

  assign io_output = io_q;
`else
  logic unused_io;

  assign unused_io = ^{io_input, io_we};
  assign io_output = '0;
`endif

endmodule

// File: tb/tb_core.sv
// Self-checking bench for core: ISA-level reference model, per-cycle compare, directed + random stimulus.
module tb_core;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [7:0]  mem_load;
  logic [7:0]  io_input;
  logic [8:0]  instruction_addr;
  logic        mem_en_load;
  logic        mem_en_store;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_store;
  logic [7:0]  io_output;

  core dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .mem_load         (mem_load),
    .io_input         (io_input),
    .instruction_addr (instruction_addr),
    .mem_en_load      (mem_en_load),
    .mem_en_store     (mem_en_store),
    .mem_addr         (mem_addr),
    .mem_store        (mem_store),
    .io_output        (io_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: plain integers, updated once per rising edge.
  int m_pc;
  int m_r [4];
  int m_z;
  int m_c;
  int m_io;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int op, rd, rs, imm, a, b, res, npc;
    op  = int'(instruction[15:12]);
    rd  = int'(instruction[11:10]);
    rs  = int'(instruction[9:8]);
    imm = int'(instruction[7:0]);
    if (rst) begin
      m_pc = 0; m_z = 0; m_c = 0; m_io = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      a   = m_r[rd];
      b   = (op == 9) ? imm : m_r[rs];
      npc = (m_pc + 1) % 512;
      res = 0;
      case (op)
        1: m_r[rd] = imm;
        2: m_r[rd] = int'(mem_load);
        4, 9: begin res = (a + b) % 256; m_c = (a + b > 255); end
        5, 10: begin res = (a - b + 256) % 256; m_c = (a < b); end
        6: begin res = a & b; m_c = 0; end
        7: begin res = a | b; m_c = 0; end
        8: begin res = a ^ b; m_c = 0; end
        11: npc = int'(instruction[8:0]);
        12: if (m_z != 0) npc = int'(instruction[8:0]);
        13: if (m_c != 0) npc = int'(instruction[8:0]);
`ifdef CORE_IO_EN
        14: m_r[rd] = int'(io_input);
        15: m_io = a;
`endif
        default: ;
      endcase
      if (op >= 4 && op <= 10) begin
        m_z = (res == 0);
        if (op != 10) m_r[rd] = res;
      end
      m_pc = npc;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    int op;
    bit ld, st;
    if (m_valid) begin
      op = int'(instruction[15:12]);
      ld = !rst && op == 2;
      st = !rst && op == 3;
      check("instruction_addr", 32'(instruction_addr), 32'(m_pc));
      check("mem_en_load", 32'(mem_en_load), 32'(ld));
      check("mem_en_store", 32'(mem_en_store), 32'(st));
      check("mem_addr", 32'(mem_addr), (ld || st) ? 32'(instruction[9:0]) : 32'd0);
      check("mem_store", 32'(mem_store), st ? 32'(m_r[int'(instruction[11:10])]) : 32'd0);
      check("io_output", 32'(io_output), 32'(m_io));
    end
  end

  task automatic step(input logic [15:0] ins, input logic [7:0] ml, input logic r);
    @(posedge clk);
    #1;
    instruction = ins;
    mem_load    = ml;
    rst         = r;
    io_input    = 8'($urandom_range(0, 255));
    @(negedge clk);
  endtask

  logic [8:0] ip_before;

  initial begin
    rst         = 1'b1;
    instruction = 16'h0000;
    mem_load    = 8'h00;
    io_input    = 8'h00;

    // Reset held two cycles.
    step(16'h0000, 8'h00, 1'b1);
    step(16'h0000, 8'h00, 1'b1);
    check("rst_ip", 32'(instruction_addr), 32'h000);
    check("rst_en_load", 32'(mem_en_load), 32'h0);
    check("rst_en_store", 32'(mem_en_store), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);

    // LDI then ST to top of data memory.
    step(16'h145A, 8'h00, 1'b0);
    step(16'h37FF, 8'h00, 1'b0);
    check("st_ip", 32'(instruction_addr), 32'h001);
    check("st_en_store", 32'(mem_en_store), 32'h1);
    check("st_addr", 32'(mem_addr), 32'h3FF);
    check("st_data", 32'(mem_store), 32'h5A);
    check("st_en_load", 32'(mem_en_load), 32'h0);

    // LD then ST of the loaded register.
    step(16'h2810, 8'hC3, 1'b0);
    check("ld_en_load", 32'(mem_en_load), 32'h1);
    check("ld_addr", 32'(mem_addr), 32'h010);
    step(16'h3811, 8'h00, 1'b0);
    check("ld_st_data", 32'(mem_store), 32'hC3);

    // ADD producing zero with carry; JZ taken.
    step(16'h10FF, 8'h00, 1'b0);
    step(16'h1401, 8'h00, 1'b0);
    step(16'h4100, 8'h00, 1'b0);
    step(16'hC040, 8'h00, 1'b0);
    step(16'h0000, 8'h00, 1'b0);
    check("jz_taken_ip", 32'(instruction_addr), 32'h040);
    step(16'h3000, 8'h00, 1'b0);
    check("add_wrap_r0", 32'(mem_store), 32'h00);

    // Non-zero sum: JZ falls through.
    step(16'h10FE, 8'h00, 1'b0);
    step(16'h1401, 8'h00, 1'b0);
    step(16'h4100, 8'h00, 1'b0);
    step(16'hC040, 8'h00, 1'b0);
    ip_before = instruction_addr;
    step(16'h0000, 8'h00, 1'b0);
    check("jz_not_taken_ip", 32'(instruction_addr), 32'(ip_before + 9'd1));

    // JMP to last address then wrap.
    step(16'hB1FF, 8'h00, 1'b0);
    step(16'h0000, 8'h00, 1'b0);
    check("jmp_ip", 32'(instruction_addr), 32'h1FF);
    step(16'h0000, 8'h00, 1'b0);
    check("wrap_ip", 32'(instruction_addr), 32'h000);

    // Reset during ST aborts it and clears every register.
    step(16'h1011, 8'h00, 1'b0);
    step(16'h1522, 8'h00, 1'b0);
    step(16'h1933, 8'h00, 1'b0);
    step(16'h1D44, 8'h00, 1'b0);
    step(16'h3C00, 8'h00, 1'b1);
    check("rst_st_en_store", 32'(mem_en_store), 32'h0);
    check("rst_st_data", 32'(mem_store), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(16'h3000 | 16'(i << 10), 8'h00, 1'b0);
      if (i == 0) check("rst_next_ip", 32'(instruction_addr), 32'h000);
      check($sformatf("rst_r%0d", i), 32'(mem_store), 32'h00);
    end

    // Random instruction stream with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      step(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
